// File: rtl/median_hist_sequencer_if.sv
// Host-side and datapath-side signals of the median/histogram sequencer.
// master = sequencer view, slave = host/datapath view.
interface median_hist_sequencer_if;
    logic        loadReq;
    logic        runReq;
    logic        hostAbort;
    logic [12:0] thresholdIn;
    logic        pixelIn;
    logic        pixelValid;
    logic        loadReady;
    logic        imgReady;
    logic        writeMem;
    logic [7:0]  xAddressIn;
    logic [7:0]  yAddressIn;
    logic        dataIn;
    logic        start;
    logic [12:0] threshold;
    logic        readHistogram;
    logic        readMedianImage;
    logic        wakeUp;
    logic        fullImageDone;
    logic        xValid;
    logic        yValid;
    logic        medianAddrValid;
    logic        busy;
    logic        done;
    logic        error;
    logic [2:0]  stateOut;

    modport master (
        input  loadReq, runReq, hostAbort, thresholdIn, pixelIn, pixelValid,
               imgReady, wakeUp, fullImageDone, xValid, yValid,
        output loadReady, writeMem, xAddressIn, yAddressIn, dataIn, start,
               threshold, readHistogram, readMedianImage, medianAddrValid,
               busy, done, error, stateOut
    );

    modport slave (
        output loadReq, runReq, hostAbort, thresholdIn, pixelIn, pixelValid,
               imgReady, wakeUp, fullImageDone, xValid, yValid,
        input  loadReady, writeMem, xAddressIn, yAddressIn, dataIn, start,
               threshold, readHistogram, readMedianImage, medianAddrValid,
               busy, done, error, stateOut
    );
endinterface

// File: rtl/median_hist_sequencer.sv
// Load / filter / histogram / readout sequencer for the median-filter datapath.
// Owns every datapath control; adds phase timeouts and a host abort.
module median_hist_sequencer #(
    parameter int X_MAX          = 255,
    parameter int Y_MAX          = 255,
    parameter int TIMEOUT_CYCLES = 2**20,
    parameter int READ_LAT       = 1
) (
    input logic                     clk,
    input logic                     reset,
    median_hist_sequencer_if.master bus
);
    localparam int            TW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LIM    = TW'(TIMEOUT_CYCLES);
    localparam logic [7:0]    X_LAST     = 8'(X_MAX);
    localparam logic [7:0]    Y_LAST     = 8'(Y_MAX);
    localparam logic [8:0]    X_BINS     = 9'(X_MAX + 1);
    localparam logic [8:0]    Y_BINS     = 9'(Y_MAX + 1);
    localparam logic [1:0]    DRAIN_LAST = 2'(READ_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_START  = 3'd2,
        S_FILTER = 3'd3,
        S_HIST   = 3'd4,
        S_READ   = 3'd5,
        S_DONE   = 3'd6,
        S_ERROR  = 3'd7
    } state_t;

    state_t        state, state_nxt;
    logic [7:0]    cx, cy;
    logic          fin;
    logic [7:0]    wx, wy;
    logic          wd, wv;
    logic [8:0]    xcnt, ycnt;
    logic [TW-1:0] tmo;
    logic [1:0]    drain;
    logic          loaded;
    logic [12:0]   thr;

    logic          accept, issue, at_last;
    logic [7:0]    x_next, y_next;
    logic [TW-1:0] tmo_inc;
    logic          tmo_hit;
    logic [8:0]    xcnt_nxt, ycnt_nxt;
    logic          hist_done;
    logic          unused_wake;

    // One raster cursor serves both the load and the readout scan.
    assign accept    = (state == S_LOAD) && !fin && bus.pixelValid;
    assign issue     = (state == S_READ) && !fin && bus.imgReady;
    assign at_last   = (cx == X_LAST) && (cy == Y_LAST);
    assign x_next    = (cx == X_LAST) ? 8'd0 : cx + 8'd1;
    assign y_next    = (cx == X_LAST) ? cy + 8'd1 : cy;
    assign tmo_inc   = (tmo == TMO_LIM) ? tmo : tmo + 1'b1;
    assign tmo_hit   = (tmo_inc == TMO_LIM);
    assign xcnt_nxt  = xcnt + {8'd0, bus.xValid && (xcnt != X_BINS)};
    assign ycnt_nxt  = ycnt + {8'd0, bus.yValid && (ycnt != Y_BINS)};
    assign hist_done = (xcnt_nxt == X_BINS) && (ycnt_nxt == Y_BINS);

    assign bus.busy      = (state != S_IDLE);
    assign bus.stateOut  = state;
    assign bus.threshold = thr;
    assign unused_wake   = bus.wakeUp;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt           = state;
        bus.loadReady       = 1'b0;
        bus.writeMem        = 1'b0;
        bus.dataIn          = 1'b0;
        bus.xAddressIn      = 8'd0;
        bus.yAddressIn      = 8'd0;
        bus.start           = 1'b0;
        bus.readHistogram   = 1'b0;
        bus.readMedianImage = 1'b0;
        bus.done            = 1'b0;
        bus.error           = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus.loadReq)                state_nxt = S_LOAD;
                else if (bus.runReq && loaded)  state_nxt = S_START;
            end
            S_LOAD: begin
                bus.loadReady  = !fin;
                bus.writeMem   = wv;
                bus.dataIn     = wd;
                bus.xAddressIn = wx;
                bus.yAddressIn = wy;
                if (fin) state_nxt = S_IDLE;
            end
            S_START: begin
                bus.start = 1'b1;
                state_nxt = S_FILTER;
            end
            S_FILTER: begin
                if (bus.fullImageDone) state_nxt = S_HIST;
                else if (tmo_hit)      state_nxt = S_ERROR;
            end
            S_HIST: begin
                bus.readHistogram = 1'b1;
                if (hist_done)    state_nxt = S_READ;
                else if (tmo_hit) state_nxt = S_ERROR;
            end
            S_READ: begin
                bus.readMedianImage = 1'b1;
                bus.xAddressIn      = cx;
                bus.yAddressIn      = cy;
                if (READ_LAT == 0) begin
                    if (issue && at_last) state_nxt = S_DONE;
                end else if (fin && (drain == DRAIN_LAST)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                bus.done  = 1'b1;
                state_nxt = S_IDLE;
            end
            S_ERROR: begin
                bus.error = 1'b1;
            end
        endcase
        if (bus.hostAbort) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cx <= '0; cy <= '0; fin <= 1'b0;
            wx <= '0; wy <= '0; wd <= 1'b0; wv <= 1'b0;
            xcnt <= '0; ycnt <= '0; tmo <= '0; drain <= '0;
            loaded <= 1'b0; thr <= '0;
        end else if (bus.hostAbort) begin
            cx <= '0; cy <= '0; fin <= 1'b0; wv <= 1'b0;
            xcnt <= '0; ycnt <= '0; tmo <= '0; drain <= '0;
            if (state == S_LOAD) loaded <= 1'b0;
        end else begin
            wv <= accept;
            if (accept) begin
                wx <= cx;
                wy <= cy;
                wd <= bus.pixelIn;
            end
            if (accept || issue) begin
                if (at_last) fin <= 1'b1;
                else begin
                    cx <= x_next;
                    cy <= y_next;
                end
            end
            if (state == S_FILTER || state == S_HIST) tmo <= tmo_inc;
            if (state == S_HIST) begin
                xcnt <= xcnt_nxt;
                ycnt <= ycnt_nxt;
            end
            if (state == S_READ && fin) drain <= drain + 2'd1;
            if (state == S_LOAD && fin) loaded <= 1'b1;
            if (state == S_IDLE && state_nxt == S_START) thr <= bus.thresholdIn;
            // Every phase change starts the next phase with fresh cursors and counters.
            if (state_nxt != state) begin
                cx <= '0; cy <= '0; fin <= 1'b0;
                xcnt <= '0; ycnt <= '0; tmo <= '0; drain <= '0;
                if (state_nxt == S_LOAD) begin
                    wx <= '0; wy <= '0; wd <= 1'b0;
                end
            end
        end
    end

    generate
        if (READ_LAT == 0) begin : g_lat0
            assign bus.medianAddrValid = issue;
        end else begin : g_lat
            logic [READ_LAT:1] vld_pipe;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)             vld_pipe <= '0;
                else if (bus.hostAbort) vld_pipe <= '0;
                else                    vld_pipe <= READ_LAT'({vld_pipe, issue});
            end
            assign bus.medianAddrValid = vld_pipe[READ_LAT];
        end
    endgenerate
endmodule
